// File: rtl/mips32_multicycle.sv
// Multicycle MIPS32 core: an FSM-sequenced datapath sharing one ALU and one unified
// valid/ready memory port for instruction fetch and data access.
module mips32_multicycle #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ADDR_W       = 32,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              retire,
  output logic              halted,
  output logic [31:0]       pc_dbg
);

  localparam int unsigned NUM_GPR = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_ILLEGAL, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] ir, ir_next;
  logic [31:0] a, a_next;
  logic [31:0] b, b_next;
  logic [31:0] alu_out, alu_next;
  logic [31:0] mdr, mdr_next;

  logic [31:0] gpr [NUM_GPR];
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;

  logic              mem_req_next, mem_we_next, halted_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [31:0]       mem_wdata_next;

  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_t     alu_op, funct_op;
  logic        funct_ok;
  logic        xfer;

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, rs_val, rt_val;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : gpr[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : gpr[rt];

  // A transfer only completes against a request that is actually on the port
  assign xfer   = mem_req & mem_ready;
  assign pc_dbg = pc;

  always_comb begin
    funct_op = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'h20:   funct_op = ALU_ADD;
      6'h22:   funct_op = ALU_SUB;
      6'h24:   funct_op = ALU_AND;
      6'h25:   funct_op = ALU_OR;
      6'h2A:   funct_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  // Shared ALU: operand selection depends only on state, never on the ALU result
  always_comb begin
    alu_a  = pc;
    alu_b  = 32'd4;
    alu_op = ALU_ADD;
    case (state)
      S_DECODE: alu_b = {imm_sext[29:0], 2'b00};
      S_MEMADR, S_ADDIEX: begin
        alu_a = a;
        alu_b = imm_sext;
      end
      S_EXEC: begin
        alu_a  = a;
        alu_b  = b;
        alu_op = funct_op;
      end
      default: ;
    endcase
    alu_y = alu_a + alu_b;
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    a_next     = a;
    b_next     = b;
    alu_next   = alu_out;
    mdr_next   = mdr;
    gpr_we     = 1'b0;
    gpr_waddr  = rt;
    gpr_wdata  = alu_out;
    retire     = 1'b0;

    case (state)
      S_FETCH: begin
        if (xfer) begin
          ir_next    = mem_rdata;
          pc_next    = alu_y;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        a_next   = rs_val;
        b_next   = rt_val;
        alu_next = alu_y;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_next   = alu_y;
        state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        if (xfer) begin
          mdr_next   = mem_rdata;
          state_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        gpr_we     = 1'b1;
        gpr_wdata  = mdr;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        if (xfer) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        if (funct_ok) begin
          alu_next   = alu_y;
          state_next = S_ALUWB;
        end else begin
          state_next = S_ILLEGAL;
        end
      end
      S_ALUWB: begin
        gpr_we     = 1'b1;
        gpr_waddr  = rd;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        if (a == b) pc_next = alu_out;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alu_next   = alu_y;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        gpr_we     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_next    = {pc[31:28], ir[25:0], 2'b00};
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ILLEGAL: begin
        if (ILLEGAL_HALT) begin
          state_next = S_HALT;
        end else begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase

    // Port outputs are registered from the state being entered, so a request
    // is on the port from the first cycle of every memory state.
    mem_req_next   = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = '0;
    mem_wdata_next = 32'd0;
    case (state_next)
      S_FETCH: begin
        mem_req_next  = 1'b1;
        mem_addr_next = pc_next[ADDR_W-1:0];
      end
      S_MEMRD: begin
        mem_req_next  = 1'b1;
        mem_addr_next = alu_next[ADDR_W-1:0];
      end
      S_MEMWR: begin
        mem_req_next   = 1'b1;
        mem_we_next    = 1'b1;
        mem_addr_next  = alu_next[ADDR_W-1:0];
        mem_wdata_next = b_next;
      end
      default: ;
    endcase
    halted_next = (state_next == S_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= 32'd0;
      a         <= 32'd0;
      b         <= 32'd0;
      alu_out   <= 32'd0;
      mdr       <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      halted    <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      ir        <= ir_next;
      a         <= a_next;
      b         <= b_next;
      alu_out   <= alu_next;
      mdr       <= mdr_next;
      mem_req   <= mem_req_next;
      mem_we    <= mem_we_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      halted    <= halted_next;
    end
  end

  // Register file; $0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= 32'd0;
    end else if (gpr_we && (gpr_waddr != 5'd0)) begin
      gpr[gpr_waddr] <= gpr_wdata;
    end
  end

endmodule

// File: tb/tb_mips32_multicycle.sv
// Directed bench for mips32_multicycle: runs a small program and checks the bus
// transaction log, retire timing, wait states, illegal-op handling and reset.
module tb_mips32_multicycle;

  logic        clk = 1'b0;
  logic        rst, rst1, ready0, ready_plan;
  logic        req0, we0, ret0, halt0;
  logic [31:0] addr0, wdata0, rdata0, pc0;
  logic        req1, we1, ret1, halt1;
  logic [31:0] addr1, wdata1, rdata1, pc1;

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [64];

  int checks = 0;
  int failures = 0;
  int rcnt, first_ret, cyc;
  logic [31:0] rd_q[$], wa_q[$], wd_q[$];
  logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];

  always #5 clk = ~clk;

  assign rdata0 = mem0[addr0[11:2]];
  assign rdata1 = mem1[addr1[7:2]];

  mips32_multicycle #(.RESET_PC(32'h100), .ADDR_W(32), .ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_ready(ready0), .mem_rdata(rdata0),
    .retire(ret0), .halted(halt0), .pc_dbg(pc0));

  mips32_multicycle #(.RESET_PC(32'h0), .ADDR_W(32), .ILLEGAL_HALT(1'b0)) dut_nohalt (
    .clk(clk), .rst(rst1), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_ready(1'b1), .mem_rdata(rdata1),
    .retire(ret1), .halted(halt1), .pc_dbg(pc1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    rcnt = 0;
    first_ret = -1;
    cyc = 0;
  endtask

  // Sample the main core at a negedge, then apply ready_plan for the next cycle
  task automatic tick();
    if (req0 && ready0) begin
      if (we0) begin
        wa_q.push_back(addr0);
        wd_q.push_back(wdata0);
        mem0[addr0[11:2]] = wdata0;
      end else begin
        rd_q.push_back(addr0);
      end
    end
    if (ret0) begin
      if (first_ret < 0) first_ret = cyc;
      rcnt++;
    end
    cyc++;
    @(posedge clk);
    #1 ready0 = ready_plan;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_log(input string tag, input int exp_ret);
    check_eq($sformatf("%s nreads", tag), 32'(rd_q.size()), 32'(exp_rd.size()));
    foreach (exp_rd[i])
      check_eq($sformatf("%s read%0d", tag, i), (i < rd_q.size()) ? rd_q[i] : 32'hxxxx_xxxx, exp_rd[i]);
    check_eq($sformatf("%s nwrites", tag), 32'(wa_q.size()), 32'(exp_wa.size()));
    foreach (exp_wa[i]) begin
      check_eq($sformatf("%s waddr%0d", tag, i), (i < wa_q.size()) ? wa_q[i] : 32'hxxxx_xxxx, exp_wa[i]);
      check_eq($sformatf("%s wdata%0d", tag, i), (i < wd_q.size()) ? wd_q[i] : 32'hxxxx_xxxx, exp_wd[i]);
    end
    check_eq($sformatf("%s retires", tag), 32'(rcnt), 32'(exp_ret));
  endtask

  initial begin
    logic [31:0] prog [27];
    prog = '{32'h20010005, 32'h2002FFFD, 32'h00221822, 32'h0041202A,
             32'hAC030008, 32'h8C050008, 32'h10210002, 32'hFC000000,
             32'hFC000000, 32'h10220005, 32'h20000007, 32'hAC04000C,
             32'hAC050010, 32'hAC000014, 32'h00223825, 32'h00224024,
             32'h00E84820, 32'hAC070018, 32'hAC09001C, 32'h08000058,
             32'hFC000000, 32'hFC000000, 32'hFC000000, 32'hFC000000,
             32'h0022502A, 32'hAC0A0020, 32'hFC000000};
    for (int i = 0; i < 1024; i++) mem0[i] = 32'd0;
    for (int i = 0; i < 27; i++) mem0[64 + i] = prog[i];
    for (int i = 0; i < 64; i++) mem1[i] = 32'd0;
    mem1[0] = 32'hFC000000;
    mem1[1] = 32'h20010009;
    mem1[2] = 32'hAC010040;
    mem1[3] = 32'h08000003;

    rst = 1'b0;
    rst1 = 1'b0;
    ready0 = 1'b1;
    ready_plan = 1'b1;

    // Reset: outputs quiet, PC at the reset vector
    repeat (3) @(negedge clk);
    check_eq("rst mem_req", 32'(req0), 32'd0);
    check_eq("rst mem_we", 32'(we0), 32'd0);
    check_eq("rst mem_addr", addr0, 32'd0);
    check_eq("rst mem_wdata", wdata0, 32'd0);
    check_eq("rst retire", 32'(ret0), 32'd0);
    check_eq("rst halted", 32'(halt0), 32'd0);
    check_eq("rst pc", pc0, 32'h100);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("boot mem_req", 32'(req0), 32'd1);
    check_eq("boot mem_addr", addr0, 32'h100);
    check_eq("boot mem_we", 32'(we0), 32'd0);

    // addi, addi, sub, slt: 4 cycles each
    clear_log();
    run(16);
    exp_rd = '{32'h100, 32'h104, 32'h108, 32'h10C};
    exp_wa.delete();
    exp_wd.delete();
    check_log("alu", 4);
    check_eq("alu first retire cycle", 32'(first_ret), 32'd3);

    // sw $3,8($0) stores 5-(-3)=8
    clear_log();
    run(4);
    exp_rd = '{32'h110};
    exp_wa = '{32'h8};
    exp_wd = '{32'h8};
    check_log("sw", 1);

    // lw $5,8($0) with three wait cycles in MEMRD
    clear_log();
    for (int k = 0; k < 8; k++) begin
      ready_plan = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
      if (k >= 3 && k <= 5) begin
        check_eq($sformatf("lw wait%0d req", k), 32'(req0), 32'd1);
        check_eq($sformatf("lw wait%0d addr", k), addr0, 32'h8);
        check_eq($sformatf("lw wait%0d we", k), 32'(we0), 32'd0);
      end
      tick();
    end
    ready_plan = 1'b1;
    exp_rd = '{32'h114, 32'h8};
    exp_wa.delete();
    exp_wd.delete();
    check_log("lw", 1);
    check_eq("lw retire cycle", 32'(first_ret), 32'd7);

    // beq taken 0x118->0x124, beq not taken, addi $0, stores of $4,$5,$0
    clear_log();
    run(22);
    exp_rd = '{32'h118, 32'h124, 32'h128, 32'h12C, 32'h130, 32'h134};
    exp_wa = '{32'hC, 32'h10, 32'h14};
    exp_wd = '{32'h1, 32'h8, 32'h0};
    check_log("branch", 6);

    // or, and, add (wraps), stores, then j to 0x160
    clear_log();
    run(23);
    exp_rd = '{32'h138, 32'h13C, 32'h140, 32'h144, 32'h148, 32'h14C};
    exp_wa = '{32'h18, 32'h1C};
    exp_wd = '{32'hFFFF_FFFD, 32'h2};
    check_log("logic", 6);

    // slt false case after the jump
    clear_log();
    run(8);
    exp_rd = '{32'h160, 32'h164};
    exp_wa = '{32'h20};
    exp_wd = '{32'h0};
    check_log("jump", 2);

    // Illegal opcode halts without retiring
    clear_log();
    run(6);
    exp_rd = '{32'h168};
    exp_wa.delete();
    exp_wd.delete();
    check_log("illegal", 0);
    check_eq("halt halted", 32'(halt0), 32'd1);
    check_eq("halt mem_req", 32'(req0), 32'd0);
    check_eq("halt pc", pc0, 32'h16C);

    // Reset abandons a store stalled in MEMWR
    mem0[64] = 32'hAC000028;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst2 halted", 32'(halt0), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst2 boot addr", addr0, 32'h100);
    clear_log();
    tick();
    tick();
    ready_plan = 1'b0;
    tick();
    check_eq("memwr req", 32'(req0), 32'd1);
    check_eq("memwr we", 32'(we0), 32'd1);
    check_eq("memwr addr", addr0, 32'h28);
    rst = 1'b0;
    #1;
    check_eq("abort mem_req", 32'(req0), 32'd0);
    check_eq("abort mem_we", 32'(we0), 32'd0);
    ready0 = 1'b1;
    ready_plan = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("restart req", 32'(req0), 32'd1);
    check_eq("restart addr", addr0, 32'h100);
    check_eq("restart pc", pc0, 32'h100);

    // Second core: illegal op retires as a NOP and fetch continues at PC+4
    rst1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_log();
    for (int k = 0; k < 11; k++) begin
      if (req1) begin
        if (we1) begin
          wa_q.push_back(addr1);
          wd_q.push_back(wdata1);
        end else begin
          rd_q.push_back(addr1);
        end
      end
      if (ret1) begin
        if (first_ret < 0) first_ret = cyc;
        rcnt++;
      end
      cyc++;
      @(negedge clk);
    end
    exp_rd = '{32'h0, 32'h4, 32'h8};
    exp_wa = '{32'h40};
    exp_wd = '{32'h9};
    check_log("nohalt", 3);
    check_eq("nohalt first retire", 32'(first_ret), 32'd2);
    check_eq("nohalt halted", 32'(halt1), 32'd0);
    check_eq("nohalt pc", pc1, 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
